// File: rtl/axi2ahb_burst_ctrl.sv
// AHB master control for the AXI-to-AHB bridge: splits one AXI command into
// 1 KB-safe INCR16/8/4/SINGLE sub-bursts. Optional abort-on-ERROR: AXI2AHB_ERR_ABORT_EN.
module axi2ahb_burst_ctrl #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 8,
    parameter int FFD       = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic [ADDR_BITS-1:0] HADDR,
    output logic [2:0]           HBURST,
    output logic [2:0]           HSIZE,
    output logic [1:0]           HTRANS,
    output logic                 HWRITE,
    input  logic                 HREADY,
    input  logic                 HRESP,
    input  logic                 cmd_empty,
    input  logic                 cmd_read,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    input  logic [LEN_BITS-1:0]  cmd_len,
    input  logic [1:0]           cmd_size,
    input  logic                 rdata_ready,
    input  logic                 wdata_ready,
    output logic                 ahb_finish,
    output logic                 ahb_error,
    output logic                 rdata_phase,
    output logic                 wdata_phase,
    output logic                 data_last
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] B_SINGLE = 3'b000;
    localparam logic [2:0] B_INCR4  = 3'b011;
    localparam logic [2:0] B_INCR8  = 3'b101;
    localparam logic [2:0] B_INCR16 = 3'b111;
    localparam int         RW       = LEN_BITS + 1;
    localparam int         unused_cfg = FFD + DATA_BITS;

    // Largest legal burst that fits both the remaining beats and the 1 KB page.
    function automatic logic [2:0] burst_of(input logic [9:0] addr, input logic [1:0] size,
                                            input logic [RW-1:0] remain);
        logic [10:0] to_bnd;
        logic [11:0] n;
        to_bnd = (11'd1024 - {1'b0, addr}) >> size;
        n      = (12'(remain) < {1'b0, to_bnd}) ? 12'(remain) : {1'b0, to_bnd};
        if (n >= 12'd16)     burst_of = B_INCR16;
        else if (n >= 12'd8) burst_of = B_INCR8;
        else if (n >= 12'd4) burst_of = B_INCR4;
        else                 burst_of = B_SINGLE;
    endfunction

    function automatic logic [4:0] beats_of(input logic [2:0] burst);
        case (burst)
            B_INCR16: beats_of = 5'd16;
            B_INCR8:  beats_of = 5'd8;
            B_INCR4:  beats_of = 5'd4;
            default:  beats_of = 5'd1;
        endcase
    endfunction

    htrans_t              htrans_r;
    logic [2:0]           hburst_r;
    logic [2:0]           hsize_r;
    logic                 hwrite_r;
    logic [ADDR_BITS-1:0] haddr_r;
    logic [RW-1:0]        remain_r;
    logic [4:0]           beat_cnt_r;
    logic                 in_flight_r;
    logic                 rdata_phase_r;
    logic                 wdata_phase_r;

    logic                 data_ready_s;
    logic                 ack_s;
    logic                 data_phase_s;
    logic                 start_s;
    logic                 final_ack_s;
    logic                 data_last_s;
    logic                 resume_ok_s;
    logic [ADDR_BITS-1:0] haddr_inc_s;
    logic [RW-1:0]        remain_dec_s;
    logic [RW-1:0]        start_remain_s;
    logic [2:0]           start_burst_s;
    logic [2:0]           next_burst_s;
    logic [2:0]           resume_burst_s;

    assign data_ready_s   = cmd_read ? rdata_ready : wdata_ready;
    assign ack_s          = htrans_r[1] & HREADY;
    assign data_phase_s   = rdata_phase_r | wdata_phase_r;
    assign start_s        = ~cmd_empty & data_ready_s & ~in_flight_r & (HREADY | ~data_phase_s);
    assign final_ack_s    = ack_s & in_flight_r & (remain_r == RW'(1));
    assign data_last_s    = HREADY & ((htrans_r == IDLE) | (htrans_r == NONSEQ));
    assign haddr_inc_s    = haddr_r + (ADDR_BITS'(1) << hsize_r);
    assign remain_dec_s   = remain_r - RW'(1);
    assign start_remain_s = {1'b0, cmd_len} + RW'(1);
    assign start_burst_s  = burst_of(cmd_addr[9:0], cmd_size, start_remain_s);
    assign next_burst_s   = burst_of(haddr_inc_s[9:0], hsize_r[1:0], remain_dec_s);
    assign resume_burst_s = burst_of(haddr_r[9:0], hsize_r[1:0], remain_r);

`ifdef AXI2AHB_ERR_ABORT_EN
    logic err_r;
    logic err_first_s;
    logic abort_s;

    // Two-cycle ERROR: first cycle cancels the pending address, second ends the command.
    assign err_first_s = in_flight_r & ~err_r & HRESP & ~HREADY & data_phase_s;
    assign abort_s     = in_flight_r & err_r & HRESP & HREADY;
    assign resume_ok_s = ~err_r;
    assign ahb_finish  = final_ack_s | abort_s;
    assign ahb_error   = abort_s;
`else
    logic unused_hresp_s;

    assign unused_hresp_s = HRESP;
    assign resume_ok_s    = 1'b1;
    assign ahb_finish     = final_ack_s;
    assign ahb_error      = 1'b0;
`endif

    // AHB address/control sequencer; HTRANS is the state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            htrans_r      <= IDLE;
            hburst_r      <= 3'b000;
            hsize_r       <= 3'b000;
            hwrite_r      <= 1'b0;
            haddr_r       <= '0;
            remain_r      <= '0;
            beat_cnt_r    <= 5'd0;
            in_flight_r   <= 1'b0;
            rdata_phase_r <= 1'b0;
            wdata_phase_r <= 1'b0;
`ifdef AXI2AHB_ERR_ABORT_EN
            err_r         <= 1'b0;
`endif
        end else begin
            if (ack_s) begin
                rdata_phase_r <= ~hwrite_r;
                wdata_phase_r <= hwrite_r;
            end else if (data_last_s) begin
                rdata_phase_r <= 1'b0;
                wdata_phase_r <= 1'b0;
            end

            if (start_s) begin
                htrans_r    <= NONSEQ;
                haddr_r     <= cmd_addr;
                hsize_r     <= {1'b0, cmd_size};
                hwrite_r    <= ~cmd_read;
                remain_r    <= start_remain_s;
                hburst_r    <= start_burst_s;
                beat_cnt_r  <= beats_of(start_burst_s);
                in_flight_r <= 1'b1;
`ifdef AXI2AHB_ERR_ABORT_EN
                err_r       <= 1'b0;
            end else if (abort_s) begin
                htrans_r      <= IDLE;
                haddr_r       <= '0;
                remain_r      <= '0;
                beat_cnt_r    <= 5'd0;
                in_flight_r   <= 1'b0;
                err_r         <= 1'b0;
                rdata_phase_r <= 1'b0;
                wdata_phase_r <= 1'b0;
            end else if (err_first_s) begin
                htrans_r <= IDLE;
                err_r    <= 1'b1;
`endif
            end else if (ack_s) begin
                haddr_r    <= haddr_inc_s;
                remain_r   <= remain_dec_s;
                beat_cnt_r <= beat_cnt_r - 5'd1;
                if (remain_r == RW'(1)) begin
                    htrans_r    <= IDLE;
                    haddr_r     <= '0;
                    in_flight_r <= 1'b0;
                end else if (beat_cnt_r == 5'd1) begin
                    if (data_ready_s) begin
                        htrans_r   <= NONSEQ;
                        hburst_r   <= next_burst_s;
                        beat_cnt_r <= beats_of(next_burst_s);
                    end else begin
                        htrans_r <= IDLE;
                    end
                end else begin
                    htrans_r <= data_ready_s ? SEQ : BUSY;
                end
            end else if (htrans_r == IDLE && in_flight_r && data_ready_s && resume_ok_s) begin
                // Sub-burst paused at its boundary by a data stall: reissue with fresh sizing.
                htrans_r   <= NONSEQ;
                hburst_r   <= resume_burst_s;
                beat_cnt_r <= beats_of(resume_burst_s);
            end else if (htrans_r == BUSY && data_ready_s) begin
                htrans_r <= SEQ;
            end
        end
    end

    assign HADDR       = haddr_r;
    assign HBURST      = hburst_r;
    assign HSIZE       = hsize_r;
    assign HTRANS      = htrans_r;
    assign HWRITE      = hwrite_r;
    assign rdata_phase = rdata_phase_r;
    assign wdata_phase = wdata_phase_r;
    assign data_last   = data_last_s;

endmodule

// File: tb/tb_axi2ahb_burst_ctrl.sv
// Directed self-checking bench for axi2ahb_burst_ctrl (DATA_BITS=64 instance).
module tb_axi2ahb_burst_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] HADDR;
    logic [2:0]  HBURST, HSIZE;
    logic [1:0]  HTRANS;
    logic        HWRITE, HREADY, HRESP;
    logic        cmd_empty, cmd_read;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [1:0]  cmd_size;
    logic        rdata_ready, wdata_ready;
    logic        ahb_finish, ahb_error, rdata_phase, wdata_phase, data_last;

    int checks_cnt = 0;
    int errors_cnt = 0;

    int          n_ack, n_fin, n_nonseq, n_busy, n_incr16, fin_cycle;
    logic [31:0] busy_addr;
    logic [31:0] ack_addr  [0:511];
    logic [1:0]  ack_trans [0:511];
    logic [2:0]  ack_burst [0:511];
    logic [2:0]  first_size;
    logic        first_write, phase_seen, dl_after, ph_after, ph_after2;
    int          fin_total = 0;
    int          err_total = 0;

    always #5 clk = ~clk;

    axi2ahb_burst_ctrl #(.ADDR_BITS(32), .DATA_BITS(64), .LEN_BITS(8), .FFD(1)) dut (
        .clk(clk), .reset_n(reset_n), .HADDR(HADDR), .HBURST(HBURST), .HSIZE(HSIZE),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HREADY(HREADY), .HRESP(HRESP),
        .cmd_empty(cmd_empty), .cmd_read(cmd_read), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_size(cmd_size), .rdata_ready(rdata_ready), .wdata_ready(wdata_ready),
        .ahb_finish(ahb_finish), .ahb_error(ahb_error), .rdata_phase(rdata_phase),
        .wdata_phase(wdata_phase), .data_last(data_last)
    );

    always @(negedge clk) begin
        if (ahb_finish) fin_total++;
        if (ahb_error)  err_total++;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one command, record every accepted beat, pop on ahb_finish.
    task automatic run_cmd(input logic rd, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] sz, input int stall_at, input int max_cyc);
        int   stall_left;
        logic stalled;
        n_ack = 0; n_fin = 0; n_nonseq = 0; n_busy = 0; n_incr16 = 0; fin_cycle = -1;
        busy_addr = '0; phase_seen = 1'b0; stall_left = 0; stalled = 1'b0;
        dl_after = 1'b0; ph_after = 1'b0; ph_after2 = 1'b1;
        first_size = 3'b000; first_write = 1'b0;
        @(posedge clk); #1;
        cmd_empty = 1'b0; cmd_read = rd; cmd_addr = addr; cmd_len = len; cmd_size = sz;
        for (int k = 1; k <= max_cyc; k++) begin
            @(posedge clk); #2;
            if (HTRANS[1] && HREADY) begin
                if (n_ack == 0) begin
                    first_size  = HSIZE;
                    first_write = HWRITE;
                end
                if (n_ack < 512) begin
                    ack_addr[n_ack]  = HADDR;
                    ack_trans[n_ack] = HTRANS;
                    ack_burst[n_ack] = HBURST;
                end
                n_ack++;
                if (HTRANS == 2'b10)  n_nonseq++;
                if (HBURST == 3'b111) n_incr16++;
            end
            if (HTRANS == 2'b01) begin
                n_busy++;
                busy_addr = HADDR;
            end
            if (rd ? rdata_phase : wdata_phase) phase_seen = 1'b1;
            if (fin_cycle >= 0 && k == fin_cycle + 1) begin
                dl_after = data_last;
                ph_after = rd ? rdata_phase : wdata_phase;
            end
            if (fin_cycle >= 0 && k == fin_cycle + 2) ph_after2 = rd ? rdata_phase : wdata_phase;
            if (ahb_finish) begin
                n_fin++;
                if (fin_cycle < 0) fin_cycle = k;
                cmd_empty = 1'b1;
            end
            if (stall_at > 0 && n_ack == stall_at && !stalled) begin
                wdata_ready = 1'b0;
                stall_left  = 3;
                stalled     = 1'b1;
            end else if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) wdata_ready = 1'b1;
            end
            if (fin_cycle >= 0 && k >= fin_cycle + 3) break;
        end
        cmd_empty = 1'b1;
        wdata_ready = 1'b1;
        rdata_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end within time limit");
        $fatal(1);
    end

    initial begin
        int fin_before;
        reset_n = 1'b0; HREADY = 1'b1; HRESP = 1'b0; cmd_empty = 1'b1; cmd_read = 1'b0;
        cmd_addr = '0; cmd_len = '0; cmd_size = 2'd0; rdata_ready = 1'b1; wdata_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_val("rst_htrans", HTRANS, 2'b00);
        check_val("rst_hburst", HBURST, 3'b000);
        check_val("rst_hsize", HSIZE, 3'b000);
        check_val("rst_hwrite", HWRITE, 1'b0);
        check_val("rst_haddr", HADDR, 32'h0);
        check_val("rst_phases", {rdata_phase, wdata_phase}, 2'b00);
        check_val("rst_finish_error", {ahb_finish, ahb_error}, 2'b00);
        @(posedge clk); #1 reset_n = 1'b1;

        // Single INCR16 write at 0x100
        run_cmd(1'b0, 32'h100, 8'd15, 2'd2, 0, 60);
        check_val("t1_acks", n_ack, 16);
        check_val("t1_burst", ack_burst[0], 3'b111);
        check_val("t1_first_addr", ack_addr[0], 32'h100);
        check_val("t1_last_addr", ack_addr[15], 32'h13C);
        check_val("t1_fin_cycle", fin_cycle, 16);
        check_val("t1_fin_count", n_fin, 1);
        check_val("t1_size_write", {first_size, first_write}, {3'b010, 1'b1});
        check_val("t1_wphase", phase_seen, 1'b1);
        check_val("t1_data_last_after", dl_after, 1'b1);
        check_val("t1_phase_after", {ph_after, ph_after2}, 2'b10);
        check_val("t1_idle_addr", {HTRANS, HADDR}, {2'b00, 32'h0});

        // Read split at the 1 KB boundary with no gap
        run_cmd(1'b1, 32'h3F0, 8'd7, 2'd2, 0, 60);
        check_val("t2_acks", n_ack, 8);
        check_val("t2_burst0", ack_burst[0], 3'b011);
        check_val("t2_addr3", ack_addr[3], 32'h3FC);
        check_val("t2_split", {ack_trans[4], ack_burst[4], ack_addr[4]}, {2'b10, 3'b011, 32'h400});
        check_val("t2_fin_cycle", fin_cycle, 8);
        check_val("t2_rphase", phase_seen, 1'b1);

        // 256-beat 64-bit read
        run_cmd(1'b1, 32'h0, 8'd255, 2'd3, 0, 400);
        check_val("t3_acks", n_ack, 256);
        check_val("t3_nonseq", n_nonseq, 16);
        check_val("t3_incr16", n_incr16, 256);
        check_val("t3_last_addr", ack_addr[255], 32'h7F8);
        check_val("t3_fin", {n_fin, fin_cycle}, {32'd1, 32'd256});

        // Byte read hugging the boundary: all SINGLE
        run_cmd(1'b1, 32'h3FE, 8'd3, 2'd0, 0, 40);
        check_val("t4_nonseq", n_nonseq, 4);
        check_val("t4_burst", {ack_burst[0], ack_burst[1], ack_burst[2]}, 9'b000_000_000);
        check_val("t4_addrs", {ack_addr[1], ack_addr[2], ack_addr[3]}, {32'h3FF, 32'h400, 32'h401});

        // INCR8 write with a 3-cycle write-buffer stall after beat 3
        run_cmd(1'b0, 32'h200, 8'd7, 2'd2, 3, 60);
        check_val("t5_acks", n_ack, 8);
        check_val("t5_busy", n_busy, 3);
        check_val("t5_busy_addr", busy_addr, 32'h20C);
        check_val("t5_resume", {ack_trans[3], ack_addr[3]}, {2'b11, 32'h20C});
        check_val("t5_burst", ack_burst[0], 3'b101);
        check_val("t5_last_addr", ack_addr[7], 32'h21C);

`ifdef AXI2AHB_ERR_ABORT_EN
        // ERROR response on beat 2 of a 4-beat read
        n_ack = 0;
        @(posedge clk); #1;
        cmd_empty = 1'b0; cmd_read = 1'b1; cmd_addr = 32'h40; cmd_len = 8'd3; cmd_size = 2'd2;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            HREADY = (k != 3);
            HRESP  = (k == 3 || k == 4);
            #1;
            if (HTRANS[1] && HREADY) n_ack++;
            if (k == 3) check_val("err_first_seq", HTRANS, 2'b11);
            if (k == 4) begin
                check_val("err_cancel_idle", HTRANS, 2'b00);
                check_val("err_finish_error", {ahb_finish, ahb_error}, 2'b11);
                cmd_empty = 1'b1;
            end
            if (k == 5) check_val("err_after", {HTRANS, ahb_finish, rdata_phase}, 4'b0000);
        end
        HRESP = 1'b0; HREADY = 1'b1;
        check_val("err_acks", n_ack, 2);
`else
        check_val("no_error_reported", err_total, 0);
`endif

        // Asynchronous reset in the middle of a burst
        fin_before = fin_total;
        @(posedge clk); #1;
        cmd_empty = 1'b0; cmd_read = 1'b0; cmd_addr = 32'h100; cmd_len = 8'd15; cmd_size = 2'd2;
        repeat (5) @(posedge clk);
        #2;
        check_val("rstmid_seq", HTRANS, 2'b11);
        #1 reset_n = 1'b0;
        #1;
        check_val("rstmid_ctrl", {HTRANS, HBURST, HSIZE, HWRITE}, 9'b0);
        check_val("rstmid_addr", HADDR, 32'h0);
        check_val("rstmid_flags", {ahb_finish, ahb_error, rdata_phase, wdata_phase}, 4'b0);
        check_val("rstmid_not_popped", fin_total, fin_before);
        cmd_empty = 1'b1;
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check_val("rstmid_idle", HTRANS, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
